// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants for the data RAM arbiter: owner FSM encodings,
// owner flag values and the RAM width defaults shared with ram_256B.
package mp_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CPU  = 2'd1;
    localparam logic [1:0] ST_HOST = 2'd2;

    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// CPU, host and RAM bus bundle for the data RAM arbiter.
// slave = arbiter view, master = surrounding core/host/RAM view.
interface data_mem_arbiter_if
    import mp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_ack;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_read;
    logic              ram_write;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  host_req, host_we, host_addr, host_wdata,
        output host_rdata, host_ack,
        output ram_addr, ram_wdata, ram_read, ram_write,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output host_req, host_we, host_addr, host_wdata,
        input  host_rdata, host_ack,
        input  ram_addr, ram_wdata, ram_read, ram_write,
        output ram_rdata
    );

endinterface

// File: rtl/data_mem_arbiter_burst_limiter.sv
// Saturating host-beat counter with a limit compare that already
// accounts for the beat completing in the current cycle.
module burst_limiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    input  logic [3:0] limit,
    output logic       at_limit
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cnt <= 4'd0;
        end else if (inc && (cnt != 4'hF)) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign at_limit = ({1'b0, cnt} + {4'd0, inc}) >= {1'b0, limit};

endmodule

// File: rtl/data_mem_arbiter.sv
// Registered CPU/host arbiter for the shared 256-byte data RAM.
// Round-robin on ties, host bursts capped while the CPU waits.
module data_mem_arbiter
    import mp_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_arbiter_if.slave  bus
);

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic              last_owner;
    logic              cpu_beat;
    logic              host_beat;
    logic              at_limit;
    logic              lim_clr;
    logic              host_sel;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    assign cpu_beat  = reset && (state == ST_CPU) && bus.cpu_req;
    assign host_beat = reset && (state == ST_HOST) && bus.host_req;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (bus.cpu_req && bus.host_req) begin
                    state_nx = (last_owner == OWN_HOST) ? ST_CPU : ST_HOST;
                end else if (bus.cpu_req) begin
                    state_nx = ST_CPU;
                end else if (bus.host_req) begin
                    state_nx = ST_HOST;
                end
            end
            ST_CPU: begin
                if (bus.host_req) begin
                    state_nx = ST_HOST;
                end else if (!bus.cpu_req) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_HOST: begin
                if (bus.cpu_req && (at_limit || !bus.host_req)) begin
                    state_nx = ST_CPU;
                end else if (!bus.cpu_req && !bus.host_req) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign lim_clr = (state == ST_HOST) && (state_nx != ST_HOST);

    burst_limiter u_lim (
        .clk      (clk),
        .reset    (reset),
        .clr      (lim_clr),
        .inc      (host_beat),
        .limit    (4'(MAX_BURST)),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last_owner <= OWN_HOST;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                if (state_nx == ST_CPU) begin
                    last_owner <= OWN_CPU;
                end else if (state_nx == ST_HOST) begin
                    last_owner <= OWN_HOST;
                end
            end
        end
    end

    assign host_sel  = (state == ST_HOST);
    assign addr_mux  = host_sel ? bus.host_addr : bus.cpu_addr;
    assign wdata_mux = host_sel ? bus.host_wdata : bus.cpu_wdata;

    assign bus.ram_addr   = addr_mux;
    assign bus.ram_wdata  = wdata_mux;
    assign bus.ram_read   = (cpu_beat && !bus.cpu_we) ||
                            (host_beat && !bus.host_we);
    assign bus.ram_write  = (cpu_beat && bus.cpu_we) ||
                            (host_beat && bus.host_we);
    assign bus.host_ack   = host_beat;
    // Reset holds the PC frozen until the arbiter is back in IDLE.
    assign bus.cpu_stall  = !reset || (bus.cpu_req && (state != ST_CPU));
    assign bus.cpu_rdata  = bus.ram_rdata;
    assign bus.host_rdata = bus.ram_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: RAM model, per-cycle
// reference model comparison and hand-computed scenario checks.
module tb_data_mem_arbiter;
  import mp_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [256];
  assign bus.ram_rdata = ram[bus.ram_addr];
  always @(posedge clk)
    if (bus.ram_write) ram[bus.ram_addr] <= bus.ram_wdata;

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: 0 none, 1 cpu, 2 host owns the next cycle
  int m_own = 0;
  int m_last = 2;
  int m_hb = 0;
  logic [7:0] m_mem [256];

  always @(negedge clk) begin : cmp
    bit cs, hs, cr, hr;
    int nx, hb2;
    cr = bus.cpu_req;
    hr = bus.host_req;
    if (!reset) begin
      chk("rst_stall", bus.cpu_stall, 1);
      chk("rst_rd", bus.ram_read, 0);
      chk("rst_wr", bus.ram_write, 0);
      chk("rst_ack", bus.host_ack, 0);
      m_own = 0;
      m_last = 2;
      m_hb = 0;
    end else begin
      cs = (m_own == 1) && cr;
      hs = (m_own == 2) && hr;
      chk("stall", bus.cpu_stall, cr && (m_own != 1));
      chk("ack", bus.host_ack, hs);
      chk("rd", bus.ram_read,
          (cs && !bus.cpu_we) || (hs && !bus.host_we));
      chk("wr", bus.ram_write,
          (cs && bus.cpu_we) || (hs && bus.host_we));
      if (cs) begin
        chk("c_addr", bus.ram_addr, bus.cpu_addr);
        if (bus.cpu_we) begin
          chk("c_wdata", bus.ram_wdata, bus.cpu_wdata);
          m_mem[bus.cpu_addr] = bus.cpu_wdata;
        end else begin
          chk("c_rdata", bus.cpu_rdata, m_mem[bus.cpu_addr]);
        end
      end
      if (hs) begin
        chk("h_addr", bus.ram_addr, bus.host_addr);
        if (bus.host_we) begin
          chk("h_wdata", bus.ram_wdata, bus.host_wdata);
          m_mem[bus.host_addr] = bus.host_wdata;
        end else begin
          chk("h_rdata", bus.host_rdata, m_mem[bus.host_addr]);
        end
      end
      nx = m_own;
      hb2 = 0;
      case (m_own)
        0: begin
          if (cr && hr) nx = (m_last == 2) ? 1 : 2;
          else if (cr) nx = 1;
          else if (hr) nx = 2;
        end
        1: begin
          if (hr) nx = 2;
          else if (!cr) nx = 0;
        end
        default: begin
          hb2 = m_hb + (hs ? 1 : 0);
          if (cr && (hb2 >= MB || !hr)) nx = 1;
          else if (!cr && !hr) nx = 0;
        end
      endcase
      if (nx != 0 && nx != m_own) m_last = nx;
      m_hb = (nx == 2 && m_own == 2) ? hb2 : 0;
      m_own = nx;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int hidx, acks, first_ack, last_ack;
    bit a, c, cpu_done;
    int order[$];
    int exp_order[9];

    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00;
      m_mem[i] = 8'h00;
    end
    bus.cpu_req = 0; bus.cpu_we = 0;
    bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.host_req = 0; bus.host_we = 0;
    bus.host_addr = 0; bus.host_wdata = 0;

    look();
    chk("reset_stall", bus.cpu_stall, 1);
    repeat (2) cyc();
    reset = 1;
    look();
    chk("idle_stall", bus.cpu_stall, 0);
    cyc();

    // CPU write then read back
    bus.cpu_req = 1; bus.cpu_we = 1;
    bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'hA5;
    look();
    chk("t1_c0_stall", bus.cpu_stall, 1);
    chk("t1_c0_wr", bus.ram_write, 0);
    cyc();
    look();
    chk("t1_c1_wr", bus.ram_write, 1);
    chk("t1_c1_stall", bus.cpu_stall, 0);
    cyc();
    chk("t1_ram", ram[8'h10], 8'hA5);
    bus.cpu_we = 0;
    look();
    chk("t1_rd_c1", bus.ram_read, 1);
    chk("t1_rdata", bus.cpu_rdata, 8'hA5);
    cyc();
    bus.cpu_req = 0;
    cyc();

    // tie straight out of reset: CPU first, then host
    reset = 0;
    cyc();
    reset = 1;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h10;
    bus.host_req = 1; bus.host_we = 1;
    bus.host_addr = 8'h20; bus.host_wdata = 8'h3C;
    look();
    chk("t2_c0_stall", bus.cpu_stall, 1);
    chk("t2_c0_ack", bus.host_ack, 0);
    cyc();
    look();
    chk("t2_cpu_first", bus.cpu_stall, 0);
    chk("t2_cpu_ack", bus.host_ack, 0);
    cyc();
    bus.cpu_addr = 8'h20;
    look();
    chk("t2_host_ack", bus.host_ack, 1);
    chk("t2_host_stall", bus.cpu_stall, 1);
    cyc();
    bus.host_req = 0;
    look();
    chk("t2_drop_wr", bus.ram_write, 0);
    cyc();
    look();
    chk("t2_cpu_rd", bus.cpu_rdata, 8'h3C);
    cyc();
    bus.cpu_req = 0;
    cyc();
    // second tie: CPU held the RAM last, so host wins
    bus.cpu_req = 1; bus.cpu_addr = 8'h10;
    bus.host_req = 1; bus.host_addr = 8'h21; bus.host_wdata = 8'h44;
    cyc();
    look();
    chk("t2_tie2_ack", bus.host_ack, 1);
    chk("t2_tie2_stall", bus.cpu_stall, 1);
    cyc();
    bus.host_req = 0;
    cyc();
    look();
    chk("t2_tie2_cpu", bus.cpu_stall, 0);
    cyc();
    bus.cpu_req = 0;
    cyc();

    // burst cap with a pending CPU read
    hidx = 0; cpu_done = 0;
    bus.host_req = 1; bus.host_we = 1;
    bus.host_addr = 8'h00; bus.host_wdata = 8'h80;
    for (int k = 0; k < 40 && hidx < 8; k++) begin
      if (k == 1) begin
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h10;
      end
      look();
      a = bus.host_ack;
      c = bus.cpu_req && !bus.cpu_stall;
      if (a) order.push_back(hidx);
      if (c) begin
        order.push_back(100);
        chk("t3_cnt_clr", {28'd0, dut.u_lim.cnt}, 0);
      end
      cyc();
      if (a) begin
        hidx++;
        bus.host_addr = 8'(hidx);
        bus.host_wdata = 8'(8'h80 + hidx);
        if (hidx == 8) bus.host_req = 0;
      end
      if (c) begin
        bus.cpu_req = 0;
        cpu_done = 1;
      end
    end
    chk("t3_done", hidx, 8);
    chk("t3_cpu_done", cpu_done, 1);
    exp_order = '{0, 1, 2, 3, 100, 4, 5, 6, 7};
    chk("t3_len", order.size(), 9);
    for (int i = 0; i < 9 && i < order.size(); i++)
      chk("t3_order", order[i], exp_order[i]);
    chk("t3_ram4", ram[8'h04], 8'h84);
    cyc();

    // unbounded host reads with no CPU request
    acks = 0; first_ack = -1; last_ack = -1;
    bus.host_req = 1; bus.host_we = 0;
    for (int k = 0; k < 21; k++) begin
      bus.host_addr = 8'(k);
      look();
      if (bus.host_ack) begin
        acks++;
        if (first_ack < 0) first_ack = k;
        last_ack = k;
      end
      cyc();
    end
    chk("t4_acks", acks, 20);
    chk("t4_first", first_ack, 1);
    chk("t4_span", last_ack - first_ack, 19);

    // host drops its request mid-HOST
    bus.host_req = 0;
    look();
    chk("t5_rd", bus.ram_read, 0);
    chk("t5_wr", bus.ram_write, 0);
    chk("t5_ack", bus.host_ack, 0);
    cyc();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h05;
    look();
    chk("t5_idle_stall", bus.cpu_stall, 1);
    cyc();
    look();
    chk("t5_cpu_go", bus.cpu_stall, 0);
    chk("t5_rdata", bus.cpu_rdata, 8'h85);
    cyc();
    bus.cpu_req = 0;
    cyc();

    // reset during a host write burst
    bus.host_req = 1; bus.host_we = 1;
    bus.host_addr = 8'h30; bus.host_wdata = 8'h11;
    cyc();
    cyc();
    bus.host_addr = 8'h31; bus.host_wdata = 8'h22;
    look();
    chk("t6_ack31", bus.host_ack, 1);
    cyc();
    bus.host_addr = 8'h30; bus.host_wdata = 8'h5A;
    bus.cpu_req = 1; bus.cpu_addr = 8'h30;
    reset = 0;
    look();
    chk("t6_rst_wr", bus.ram_write, 0);
    chk("t6_rst_ack", bus.host_ack, 0);
    cyc();
    reset = 1;
    bus.host_req = 0;
    chk("t6_ram30", ram[8'h30], 8'h11);
    chk("t6_ram31", ram[8'h31], 8'h22);
    look();
    chk("t6_idle_stall", bus.cpu_stall, 1);
    cyc();
    look();
    chk("t6_cpu_go", bus.cpu_stall, 0);
    chk("t6_rdata", bus.cpu_rdata, 8'h11);
    cyc();
    bus.cpu_req = 0;
    look();
    chk("t6_no_req", bus.cpu_stall, 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
